// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// State enum, wait-counter width and internal error codes.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WAIT_CNT_W = 3;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;

endpackage

// File: rtl/dmem_array.sv
// Word storage with combinational read and byte-enable synchronous write.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic                clk,
  input  logic                we,
  input  logic [IDX_W-1:0]    addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] strb,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < DATA_W/8; k++) begin
        if (strb[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding data-memory controller: IDLE -> WAIT (WAIT_STATES) -> RESP.
// Optional DMEM_CTRL_ALIGN_CHECK_EN rejects misaligned addresses with an error.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [31:0]         req_addr_i,
  input  logic                req_wr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_strb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o
);

  // Handshake: a request transfers on a rising edge with req_valid_i & req_ready_o;
  // a response transfers on a rising edge with rsp_valid_o & rsp_ready_i.
  localparam int OFF_W = $clog2(DATA_W/8);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e                  state;
  logic [WAIT_CNT_W-1:0]   cnt;
  logic [31:0]             addr_q;
  logic                    wr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W/8-1:0]     strb_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    err_q;

  logic [31:0]             offset;
  logic [31:0]             index;
  logic [1:0]              err_code;
  logic                    exec;
  logic                    mem_we;
  logic [DATA_W-1:0]       arr_rdata;

  assign offset = addr_q - BASE_ADDR;
  assign index  = offset >> OFF_W;

  always_comb begin
    err_code = ERR_NONE;
    if (addr_q < BASE_ADDR || index >= 32'(DEPTH_WORDS)) begin
      err_code = ERR_RANGE;
    end
`ifdef DMEM_CTRL_ALIGN_CHECK_EN
    else if (addr_q[OFF_W-1:0] != '0) begin
      err_code = ERR_ALIGN;
    end
`endif
  end

  assign exec   = (state == WAIT) && (cnt == '0);
  assign mem_we = exec && wr_q && (err_code == ERR_NONE);

  dmem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (index[IDX_W-1:0]),
    .wdata (wdata_q),
    .strb  (strb_q),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            wr_q    <= req_wr_i;
            wdata_q <= req_wdata_i;
            strb_q  <= req_strb_i;
            cnt     <= WAIT_CNT_W'(WAIT_STATES);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            // Execute cycle: the write commits on this edge, the read samples now.
            err_q   <= (err_code != ERR_NONE);
            rdata_q <= (!wr_q && err_code == ERR_NONE) ? arr_rdata : '0;
            state   <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl (DATA_W=32, BASE_ADDR=0x1000, WAIT_STATES=2).
// Reference model is a word-indexed associative array updated per access.
module tb_dmem_ctrl;

  localparam int          DW    = 32;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h1000;
  localparam int          WS    = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total;
  int bad;

  logic [31:0] model [int];

  dmem_ctrl #(
    .DATA_W      (DW),
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_STATES (WS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_wr_i    (req_wr),
    .req_wdata_i (req_wdata),
    .req_strb_i  (req_strb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit addr_err(input logic [31:0] a);
    if (a < BASE) return 1'b1;
    if (((a - BASE) / 4) >= DEPTH) return 1'b1;
`ifdef DMEM_CTRL_ALIGN_CHECK_EN
    if ((a % 4) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic model_access(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                              input logic [3:0] sb, output logic [31:0] exp_rd, output logic exp_er);
    int w;
    logic [31:0] word;
    exp_er = addr_err(a);
    exp_rd = '0;
    if (!exp_er) begin
      w = int'((a - BASE) / 4);
      word = model.exists(w) ? model[w] : 32'h0;
      if (wr) begin
        for (int k = 0; k < 4; k++) if (sb[k]) word[8*k +: 8] = wd[8*k +: 8];
        model[w] = word;
      end else begin
        exp_rd = word;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                       input logic [3:0] sb, input int hold, input bit rel,
                       output logic [31:0] rd, output logic er, output int lat, output bit to);
    @(negedge clk);
    req_addr = a; req_wr = wr; req_wdata = wd; req_strb = sb; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    to  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (rsp_valid) begin
        to = 1'b0;
        break;
      end
    end
    rd = rsp_rdata;
    er = rsp_err;
    repeat (hold) @(posedge clk);
    if (rel) begin
      #1 rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", rsp_err); end
    @(negedge clk); rst = 1'b0; #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd, erd; logic er, eer; int lat; bit to;
    model_access(32'h1004, 1'b1, 32'hDEADBEEF, 4'hF, erd, eer);
    issue(32'h1004, 1'b1, 32'hDEADBEEF, 4'hF, 0, 1'b1, rd, er, lat, to);
    total++; if (to || lat != WS + 1) begin bad++; $display("FAIL wr_latency: got %0d (timeout=%0d) want %0d", lat, to, WS + 1); end
    total++; if (er !== eer || rd !== erd) begin bad++; $display("FAIL wr_resp: got err=%b rd=%h want err=%b rd=%h", er, rd, eer, erd); end
    model_access(32'h1004, 1'b0, 32'h0, 4'h0, erd, eer);
    issue(32'h1004, 1'b0, 32'h0, 4'h0, 0, 1'b1, rd, er, lat, to);
    total++; if (to || lat != WS + 1) begin bad++; $display("FAIL rd_latency: got %0d (timeout=%0d) want %0d", lat, to, WS + 1); end
    total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL rd_full: got err=%b rd=%h want err=0 rd=deadbeef", er, rd); end
  endtask

  task automatic test_strobe();
    logic [31:0] rd, erd; logic er, eer; int lat; bit to;
    model_access(32'h1004, 1'b1, 32'h00000055, 4'b0001, erd, eer);
    issue(32'h1004, 1'b1, 32'h00000055, 4'b0001, 0, 1'b1, rd, er, lat, to);
    issue(32'h1004, 1'b0, 32'h0, 4'h0, 0, 1'b1, rd, er, lat, to);
    total++; if (to || rd !== 32'hDEADBE55 || er !== 1'b0) begin bad++; $display("FAIL strobe_byte0: got err=%b rd=%h want err=0 rd=deadbe55", er, rd); end
    model_access(32'h1004, 1'b1, 32'hFFFFFFFF, 4'h0, erd, eer);
    issue(32'h1004, 1'b1, 32'hFFFFFFFF, 4'h0, 0, 1'b1, rd, er, lat, to);
    total++; if (to || er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL strobe_zero_resp: got err=%b rd=%h want err=0 rd=0", er, rd); end
    model_access(32'h1004, 1'b0, 32'h0, 4'h0, erd, eer);
    issue(32'h1004, 1'b0, 32'h0, 4'h0, 0, 1'b1, rd, er, lat, to);
    total++; if (to || rd !== erd) begin bad++; $display("FAIL strobe_zero_keep: got %h want %h", rd, erd); end
  endtask

  task automatic test_range();
    logic [31:0] rd, erd; logic er, eer; int lat; bit to;
    logic [31:0] addrs [3];
    addrs[0] = 32'h0FFC; addrs[1] = BASE + 32'(4 * DEPTH); addrs[2] = BASE + 32'(4 * DEPTH) + 32'h40;
    for (int i = 0; i < 3; i++) begin
      model_access(addrs[i], i == 2, 32'h11223344, 4'hF, erd, eer);
      issue(addrs[i], i == 2, 32'h11223344, 4'hF, 0, 1'b1, rd, er, lat, to);
      total++; if (to || er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL range_%0d: got err=%b rd=%h want err=1 rd=0", i, er, rd); end
    end
    model_access(32'h1004, 1'b0, 32'h0, 4'h0, erd, eer);
    issue(32'h1004, 1'b0, 32'h0, 4'h0, 0, 1'b1, rd, er, lat, to);
    total++; if (rd !== erd) begin bad++; $display("FAIL range_unchanged: got %h want %h", rd, erd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, erd; logic er, eer; int lat; bit to;
    model_access(32'h1010, 1'b1, 32'h0, 4'hF, erd, eer);
    issue(32'h1010, 1'b1, 32'h0, 4'hF, 0, 1'b1, rd, er, lat, to);
    model_access(32'h1004, 1'b0, 32'h0, 4'h0, erd, eer);
    issue(32'h1004, 1'b0, 32'h0, 4'h0, 0, 1'b0, rd, er, lat, to);
    total++; if (to || rd !== erd) begin bad++; $display("FAIL bp_first: got %h want %h", rd, erd); end
    // A write offered while the response is pending must be ignored.
    req_addr = 32'h1010; req_wr = 1'b1; req_wdata = 32'hFFFFFFFF; req_strb = 4'hF; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== erd || rsp_err !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_%0d: got v=%b rdy=%b rd=%h err=%b want v=1 rdy=0 rd=%h err=0",
                 c, rsp_valid, req_ready, rsp_rdata, rsp_err, erd);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got ready=%b want 1", req_ready); end
    model_access(32'h1010, 1'b0, 32'h0, 4'h0, erd, eer);
    issue(32'h1010, 1'b0, 32'h0, 4'h0, 0, 1'b1, rd, er, lat, to);
    total++; if (rd !== erd) begin bad++; $display("FAIL bp_ignored_req: got %h want %h", rd, erd); end
  endtask

  task automatic test_reset_wait();
    logic [31:0] rd, erd; logic er, eer; int lat; bit to;
    model_access(32'h1008, 1'b1, 32'hA5A50F0F, 4'hF, erd, eer);
    issue(32'h1008, 1'b1, 32'hA5A50F0F, 4'hF, 0, 1'b1, rd, er, lat, to);
    @(negedge clk);
    req_addr = 32'h1008; req_wr = 1'b1; req_wdata = 32'h12345678; req_strb = 4'hF; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rw_in_wait: got rdy=%b v=%b want 0 0", req_ready, rsp_valid); end
    rst = 1'b1; #1;
    total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin bad++; $display("FAIL rw_outputs: got v=%b rd=%h err=%b want 0 0 0", rsp_valid, rsp_rdata, rsp_err); end
    @(negedge clk); @(negedge clk); rst = 1'b0; #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rw_ready: got %b want 1", req_ready); end
    model_access(32'h1008, 1'b0, 32'h0, 4'h0, erd, eer);
    issue(32'h1008, 1'b0, 32'h0, 4'h0, 0, 1'b1, rd, er, lat, to);
    total++; if (to || rd !== 32'hA5A50F0F || rd !== erd) begin bad++; $display("FAIL rw_no_commit: got %h want a5a50f0f", rd); end
  endtask

  task automatic test_align();
    logic [31:0] rd, erd; logic er, eer; int lat; bit to;
    model_access(32'h1006, 1'b1, 32'hCAFEF00D, 4'hF, erd, eer);
    issue(32'h1006, 1'b1, 32'hCAFEF00D, 4'hF, 0, 1'b1, rd, er, lat, to);
    total++; if (to || lat != WS + 1 || er !== eer || rd !== 32'h0) begin bad++; $display("FAIL align_resp: got err=%b rd=%h lat=%0d want err=%b rd=0 lat=%0d", er, rd, lat, eer, WS + 1); end
    model_access(32'h1004, 1'b0, 32'h0, 4'h0, erd, eer);
    issue(32'h1004, 1'b0, 32'h0, 4'h0, 0, 1'b1, rd, er, lat, to);
    total++; if (rd !== erd) begin bad++; $display("FAIL align_storage: got %h want %h", rd, erd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, wd; logic er, eer, wr; logic [3:0] sb; int lat, hold; bit to;
    for (int k = 0; k < 8; k++) begin
      wd = $urandom;
      model_access(BASE + 32'(4 * k), 1'b1, wd, 4'hF, erd, eer);
      issue(BASE + 32'(4 * k), 1'b1, wd, 4'hF, 0, 1'b1, rd, er, lat, to);
    end
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'(4 * $urandom_range(1, 4));
        1:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
        default: a = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      endcase
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      sb = 4'($urandom_range(0, 15));
      hold = $urandom_range(0, 3);
      model_access(a, wr, wd, sb, erd, eer);
      issue(a, wr, wd, sb, hold, 1'b1, rd, er, lat, to);
      total++;
      if (to || lat != WS + 1 || er !== eer || rd !== erd) begin
        bad++;
        $display("FAIL rand_%0d a=%h wr=%b sb=%h: got err=%b rd=%h lat=%0d want err=%b rd=%h lat=%0d",
                 n, a, wr, sb, er, rd, lat, eer, erd, WS + 1);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    req_valid = 1'b0; req_addr = '0; req_wr = 1'b0; req_wdata = '0; req_strb = '0; rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_strobe();
    test_range();
    test_backpressure();
    test_reset_wait();
    test_align();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
